// File: rtl/spi_write_scheduler.sv
// spi_write_scheduler: round-robin arbiter feeding an SPI master that sends CMD, payload and tail clocks per frame
module spi_write_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV = 4,
  parameter logic [7:0] CMD = 8'h91,
  parameter int TAIL_CLKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0] ack,
  output logic busy,
  output logic done,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic sclk,
  output logic mosi,
  output logic cs_n
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int NB = 8 + DATA_BITS + TAIL_CLKS;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [DW-1:0] div, div_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [NB-1:0] sr, sr_n;
  logic [GW-1:0] ptr, ptr_n, grant_n, gi;
  logic [NUM_REQ-1:0] ack_n;
  logic busy_n, done_n, sclk_n, mosi_n, cs_n_n, tick, found;
  logic [7:0] cmd_rev;
  int idx;
  for (genvar g = 0; g < 8; g++) assign cmd_rev[g] = CMD[7-g];
  assign tick = div == DW'(CLK_DIV - 1);
  always_comb begin
    found = 1'b0;
    gi = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gi = GW'(idx);
      end
    end
  end
  // sr holds the not-yet-sent bits with the bit on mosi at the MSB; sclk doubles as the bit phase
  always_comb begin
    state_n = state;
    div_n = tick ? '0 : div + 1'b1;
    bcnt_n = bcnt;
    sr_n = sr;
    ptr_n = ptr;
    grant_n = grant_id;
    ack_n = '0;
    busy_n = busy;
    done_n = 1'b0;
    sclk_n = sclk;
    mosi_n = mosi;
    cs_n_n = cs_n;
    case (state)
      IDLE: if (found) begin
        state_n = SETUP;
        div_n = '0;
        bcnt_n = '0;
        sr_n = NB'({cmd_rev, req_data[int'(gi)*DATA_BITS +: DATA_BITS]}) << TAIL_CLKS;
        ack_n[gi] = 1'b1;
        busy_n = 1'b1;
        cs_n_n = 1'b0;
        grant_n = gi;
        ptr_n = GW'((int'(gi) + 1) % NUM_REQ);
        mosi_n = CMD[0];
      end
      SETUP: if (tick) state_n = SHIFT;
      SHIFT: if (tick) begin
        sclk_n = !sclk;
        if (sclk && bcnt == BW'(NB - 1)) state_n = HOLD;
        else if (sclk) begin
          sr_n = sr << 1;
          mosi_n = sr[NB-2];
          bcnt_n = bcnt + 1'b1;
        end
      end
      HOLD: if (tick) begin
        state_n = GAP;
        cs_n_n = 1'b1;
        mosi_n = 1'b0;
      end
      GAP: if (tick) begin
        state_n = IDLE;
        done_n = 1'b1;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bcnt <= '0;
      sr <= '0;
      ptr <= '0;
      grant_id <= '0;
      ack <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= 1'b1;
    end else begin
      state <= state_n;
      div <= div_n;
      bcnt <= bcnt_n;
      sr <= sr_n;
      ptr <= ptr_n;
      grant_id <= grant_n;
      ack <= ack_n;
      busy <= busy_n;
      done <= done_n;
      sclk <= sclk_n;
      mosi <= mosi_n;
      cs_n <= cs_n_n;
    end
  end
endmodule
